debug_bp_unit: RTL



---
 rtl/debug_pkg.sv | 20 ++
 rtl/bp_slot.sv | 53 +++++
 rtl/debug_bp_unit.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/debug_pkg.sv
// Shared types and constants for the debug breakpoint unit.
// Optional hit counters are enabled with the DEBUG_BP_HIT_COUNT_EN macro.
package debug_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        STEP   = 2'd2,
        CONT   = 2'd3
    } state_t;

    localparam int HIT_CNT_W = 8;
    localparam logic [HIT_CNT_W-1:0] HIT_SAT = 8'hFF;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bp_slot.sv
// One breakpoint slot: committed address, PC comparator and, with
// DEBUG_BP_HIT_COUNT_EN defined, a saturating hit counter.
module bp_slot
    import debug_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_commit,
    input  logic [ADDR_W-1:0]    i_commit_data,
    input  logic                 i_en,
    input  logic [ADDR_W-1:0]    i_pc,
    input  logic                 i_pc_valid,
`ifdef DEBUG_BP_HIT_COUNT_EN
    input  logic                 i_cnt_inc,
    output logic [HIT_CNT_W-1:0] o_hit_cnt,
`endif
    output logic [ADDR_W-1:0]    o_bp,
    output logic                 o_match
);

    logic [ADDR_W-1:0] r_bp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bp <= '0;
        end else if (i_commit) begin
            r_bp <= i_commit_data;
        end
    end

    assign o_bp    = r_bp;
    assign o_match = i_en & i_pc_valid & (i_pc == r_bp);

`ifdef DEBUG_BP_HIT_COUNT_EN
    logic [HIT_CNT_W-1:0] r_cnt;

    // A fresh address starts counting from zero, even if it hits in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_commit) begin
            r_cnt <= '0;
        end else if (i_cnt_inc && (r_cnt != HIT_SAT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_hit_cnt = r_cnt;
`endif

endmodule

// File: rtl/debug_bp_unit.sv
// Breakpoint / single-step controller driving the CPU halt request.
// Define DEBUG_BP_HIT_COUNT_EN to add per-slot saturating hit counters (hit_cnt).
module debug_bp_unit
    import debug_pkg::*;
#(
    parameter int NUM_BP  = 4,
    parameter int ADDR_W  = 16,
    parameter int CHUNK_W = 8
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [ADDR_W-1:0]                        pc,
    input  logic                                     pc_valid,
    input  logic                                     ld_strobe,
    input  logic [CHUNK_W-1:0]                       ld_data,
    input  logic [clog2_min1(NUM_BP)-1:0]            ld_sel,
    input  logic [NUM_BP-1:0]                        bp_en,
    input  logic                                     step_req,
    input  logic                                     cont_req,
`ifdef DEBUG_BP_HIT_COUNT_EN
    output logic [NUM_BP*HIT_CNT_W-1:0]              hit_cnt,
`endif
    output logic                                     halt,
    output logic [clog2_min1(NUM_BP)-1:0]            hit_idx,
    output logic                                     hit_valid,
    output logic [clog2_min1(ADDR_W/CHUNK_W)-1:0]    ld_phase,
    output logic [ADDR_W-1:0]                        bp_view
);

    localparam int CHUNKS = ADDR_W / CHUNK_W;
    localparam int SEL_W  = clog2_min1(NUM_BP);
    localparam int PH_W   = clog2_min1(CHUNKS);

    logic [PH_W-1:0]   r_ld_phase;
    logic [SEL_W-1:0]  r_last_sel;
    logic [ADDR_W-1:0] r_shadow;
    logic [PH_W-1:0]   w_phase_eff;
    logic              w_last_chunk;
    logic              w_sel_ok;
    logic              w_commit;
    logic [ADDR_W-1:0] w_commit_data;

    // A slot change restarts the sequence; a strobe in that cycle is chunk 0.
    assign w_phase_eff  = (ld_sel != r_last_sel) ? '0 : r_ld_phase;
    assign w_last_chunk = (w_phase_eff == PH_W'(CHUNKS - 1));
    assign w_sel_ok     = ({1'b0, ld_sel} < (SEL_W + 1)'(NUM_BP));
    assign w_commit     = ld_strobe & w_last_chunk & w_sel_ok;

    always_comb begin
        w_commit_data = '0;
        for (int k = 0; k < CHUNKS; k++) begin
            w_commit_data[k*CHUNK_W +: CHUNK_W] =
                (w_phase_eff == PH_W'(k)) ? ld_data : r_shadow[k*CHUNK_W +: CHUNK_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_phase <= '0;
            r_last_sel <= '0;
            r_shadow   <= '0;
        end else begin
            r_last_sel <= ld_sel;
            if (ld_strobe) begin
                for (int k = 0; k < CHUNKS; k++) begin
                    if (w_phase_eff == PH_W'(k)) begin
                        r_shadow[k*CHUNK_W +: CHUNK_W] <= ld_data;
                    end
                end
                r_ld_phase <= w_last_chunk ? '0 : w_phase_eff + PH_W'(1);
            end else begin
                r_ld_phase <= w_phase_eff;
            end
        end
    end

    assign ld_phase = r_ld_phase;

    logic [ADDR_W-1:0] w_bp [NUM_BP];
    logic [NUM_BP-1:0] w_match;
    logic [SEL_W-1:0]  w_win;
    logic              w_any;
    state_t            r_state;
    state_t            w_next_state;

    for (genvar g = 0; g < NUM_BP; g++) begin : g_slot
        bp_slot #(
            .ADDR_W(ADDR_W)
        ) u_slot (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_commit     (w_commit && (ld_sel == SEL_W'(g))),
            .i_commit_data(w_commit_data),
            .i_en         (bp_en[g]),
            .i_pc         (pc),
            .i_pc_valid   (pc_valid),
`ifdef DEBUG_BP_HIT_COUNT_EN
            .i_cnt_inc    ((r_state == RUN) && w_match[g] && (w_win == SEL_W'(g))),
            .o_hit_cnt    (hit_cnt[g*HIT_CNT_W +: HIT_CNT_W]),
`endif
            .o_bp         (w_bp[g]),
            .o_match      (w_match[g])
        );
    end

    // Lowest matching index wins.
    always_comb begin
        w_win = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_win = SEL_W'(i);
            end
        end
    end

    assign w_any   = |w_match;
    assign bp_view = w_sel_ok ? w_bp[ld_sel] : '0;

    logic [SEL_W-1:0] r_hit_idx;
    logic [SEL_W-1:0] w_next_hit_idx;
    logic             r_hit_valid;
    logic             w_next_hit_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_hit_idx   <= '0;
            r_hit_valid <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_hit_idx   <= w_next_hit_idx;
            r_hit_valid <= w_next_hit_valid;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_next_hit_idx   = r_hit_idx;
        w_next_hit_valid = r_hit_valid;
        case (r_state)
            RUN: begin
                if (w_any) begin
                    w_next_state     = HALTED;
                    w_next_hit_idx   = w_win;
                    w_next_hit_valid = 1'b1;
                end
            end
            HALTED: begin
                if (step_req) begin
                    w_next_state = STEP;
                end else if (cont_req) begin
                    w_next_state = CONT;
                end
            end
            STEP: begin
                if (pc_valid) begin
                    w_next_state     = HALTED;
                    w_next_hit_valid = w_any;
                    if (w_any) begin
                        w_next_hit_idx = w_win;
                    end
                end
            end
            CONT: begin
                // The fetch at the halted-at address is skipped so it cannot retrigger.
                if (pc_valid) begin
                    w_next_state = RUN;
                end
            end
            default: w_next_state = RUN;
        endcase
    end

    assign halt      = (r_state == HALTED);
    assign hit_idx   = r_hit_idx;
    assign hit_valid = r_hit_valid;

endmodule
